// File: rtl/w_input_conditioner.sv
// w_input_conditioner: synchronises and debounces the external raw_in
// level into the registered complementary pair W/_W for the Mealy detector.
// Build option: define SYNC_STAGE3_EN to add a third synchroniser flop
// (every latency figure grows by one cycle).
module w_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic W,
  output logic _W,
  output logic busy
);

`ifdef SYNC_STAGE3_EN
  localparam int SYNC_STAGES = 3;
`else
  localparam int SYNC_STAGES = 2;
`endif

  // State encoding: bit 1 is the level W is (or stays) at, bit 0 marks a
  // qualification in progress.
  localparam logic [1:0] IDLE_LOW   = 2'b00;
  localparam logic [1:0] CHECK_HIGH = 2'b01;
  localparam logic [1:0] IDLE_HIGH  = 2'b10;
  localparam logic [1:0] CHECK_LOW  = 2'b11;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  logic [1:0]             r_state;
  logic [1:0]             w_state_next;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [CNT_WIDTH-1:0]   w_cnt_next;
  logic                   w_w_next;
  logic                   w_busy_next;
  logic                   r_w;
  logic                   r_wn;
  logic                   r_busy;

  // Only the last synchroniser stage is allowed to reach the debounce FSM.
  assign w_sync = r_sync[SYNC_STAGES-1];

  // Synchroniser chain: raw_in enters at bit 0 and shifts toward the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw_in};
    end
  end

  // Debounce next-state and counter logic; an opposite-level sample during
  // a check aborts it, a full run of new-level samples commits it.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE_LOW: begin
        if (w_sync) begin
          w_state_next = CHECK_HIGH;
          w_cnt_next   = CNT_ONE;
        end else begin
          w_cnt_next   = CNT_ZERO;
        end
      end
      CHECK_HIGH: begin
        if (!w_sync) begin
          w_state_next = IDLE_LOW;
          w_cnt_next   = CNT_ZERO;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = IDLE_HIGH;
          w_cnt_next   = CNT_ZERO;
        end else begin
          w_cnt_next   = r_cnt + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!w_sync) begin
          w_state_next = CHECK_LOW;
          w_cnt_next   = CNT_ONE;
        end else begin
          w_cnt_next   = CNT_ZERO;
        end
      end
      CHECK_LOW: begin
        if (w_sync) begin
          w_state_next = IDLE_HIGH;
          w_cnt_next   = CNT_ZERO;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = IDLE_LOW;
          w_cnt_next   = CNT_ZERO;
        end else begin
          w_cnt_next   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_next = IDLE_LOW;
        w_cnt_next   = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the next state so W/_W/busy are registered in step
  // with the state they describe.
  always_comb begin
    w_w_next    = (w_state_next == IDLE_HIGH) || (w_state_next == CHECK_LOW);
    w_busy_next = (w_state_next == CHECK_HIGH) || (w_state_next == CHECK_LOW);
  end

  // State, counter and output registers; reset forces the low idle level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE_LOW;
      r_cnt   <= CNT_ZERO;
      r_w     <= 1'b0;
      r_wn    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_w     <= w_w_next;
      r_wn    <= ~w_w_next;
      r_busy  <= w_busy_next;
    end
  end

  assign W    = r_w;
  assign _W   = r_wn;
  assign busy = r_busy;

endmodule
